// File: rtl/seq_pattern_gen_pkg.sv
// Shared state encoding and constants for the serial pattern generator.
// The state enum is the reference encoding; the top mirrors it in localparams.
package seq_gen_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int   MAX_WIDTH  = 32;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/seq_pattern_gen_bit_counter.sv
// Load/decrement bit counter for seq_pattern_gen.
// It is loaded with WIDTH-1 at word start; tc marks the last bit of the word.
module seq_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // Saturates at zero so the counter never wraps while the word is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Parallel-to-serial pattern generator feeding a downstream sequence detector.
// Optional word repeat is enabled by defining SEQ_GEN_REPEAT_EN.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic             repeat_en,
`endif
  output logic             ready,
  output logic             j,
  output logic             valid,
  output logic             done
);

  localparam int               CNT_W      = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);
  localparam logic [0:0]       ST_IDLE    = 1'(IDLE);
  localparam logic [0:0]       ST_SHIFT   = 1'(SHIFT);

  logic [0:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shadow_reg;
  logic             in_shift;
  logic             accept;
  logic             last_bit;
  logic             reload;
  logic             head_bit;
  logic             tc;

  assign in_shift = (state == ST_SHIFT);
  assign accept   = (state == ST_IDLE) && start;
  assign last_bit = in_shift && tc;
  assign head_bit = (LSB_FIRST != 0) ? shift_reg[0] : shift_reg[WIDTH-1];

`ifdef SEQ_GEN_REPEAT_EN
  assign reload = last_bit && repeat_en;
`else
  assign reload = 1'b0;
`endif

  seq_bit_counter #(
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept || reload),
    .load_value(LAST_COUNT),
    .dec       (in_shift),
    .tc        (tc)
  );

  // The shadow copy lets a repeated word restart without re-sampling data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      shadow_reg <= '0;
    end else if (accept) begin
      state      <= ST_SHIFT;
      shift_reg  <= data;
      shadow_reg <= data;
    end else if (in_shift) begin
      if (reload) begin
        shift_reg <= shadow_reg;
      end else begin
        shift_reg <= (LSB_FIRST != 0) ? (shift_reg >> 1) : (shift_reg << 1);
        if (last_bit) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  assign ready = !in_shift;
  assign valid = in_shift;
  assign j     = in_shift ? head_bit : IDLE_LEVEL;
  assign done  = last_bit;

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of bits per serialized word (legal range 1..32).
REQ-002 The block SHALL have parameter LSB_FIRST, default 0, where 0 means MSB is sent first and 1 means LSB is sent first.
REQ-003 The block SHALL use a single clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have port: clk, input, 1 bit, rising-edge clock.
REQ-005 The block SHALL have port: rst, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port: start, input, 1 bit, request to serialize data.
REQ-007 The block SHALL have port: data, input, WIDTH bits, parallel word to send.
REQ-008 The block SHALL have port: ready, output, 1 bit, block idle and able to accept start.
REQ-009 The block SHALL have port: j, output, 1 bit, serial bit stream for the downstream sequence detector.
REQ-010 The block SHALL have port: valid, output, 1 bit, j carries a payload bit this cycle.
REQ-011 The block SHALL have port: done, output, 1 bit, single-cycle pulse marking the last bit of a word.

Function
REQ-012 The block SHALL implement the FSM states IDLE and SHIFT, plus RELOAD behaviour when SEQ_GEN_REPEAT_EN is defined.
REQ-013 In IDLE: ready=1, valid=0, j=0, done=0.
REQ-014 IDLE SHALL move to SHIFT on a clock edge where start=1, capturing data into a shift register and a shadow register on that edge.
REQ-015 The first bit SHALL appear on j on the cycle after the start edge, giving a latency of 1 cycle.
REQ-016 SHIFT SHALL drive exactly WIDTH consecutive bits with valid=1 and ready=0, with no gaps.
REQ-017 Bit order SHALL be data[WIDTH-1] down to data[0] when LSB_FIRST=0, and data[0] up to data[WIDTH-1] when LSB_FIRST=1.
REQ-018 The bit counter SHALL count 0..WIDTH-1 and be $clog2(WIDTH)+1 bits wide, so no wrap occurs inside a word.
REQ-019 done SHALL be high only during the cycle the last bit is on j.
REQ-020 On the edge ending the last bit, the FSM SHALL return to IDLE, with ready=1 on the following cycle.
REQ-021 start SHALL be ignored while in SHIFT, and data changes after capture SHALL have no effect on the word in flight.
REQ-022 With WIDTH=1: valid and done SHALL be high for one cycle, and a back-to-back start SHALL yield a single idle cycle between words.
REQ-023 start held high continuously SHALL yield words separated by exactly one IDLE cycle (outside repeat mode).

Reset
REQ-024 rst=1 SHALL immediately force IDLE and set j=0, valid=0, done=0, ready=1, and clear the counter and shift register, regardless of the clock.
REQ-025 Reset mid-word SHALL abort the word, and no done pulse SHALL be produced for the aborted word.
REQ-026 After rst falls, the block SHALL accept start on the next rising edge.

Configuration
REQ-027 The macro SEQ_GEN_REPEAT_EN SHALL, when defined, add the input port repeat_en (1 bit).
REQ-028 With SEQ_GEN_REPEAT_EN defined, if repeat_en=1 during the done cycle, the shift register SHALL reload from the shadow register and the first bit of the same word SHALL follow immediately, with no gap and valid held high.
REQ-029 With SEQ_GEN_REPEAT_EN defined, deasserting repeat_en SHALL take effect only at the next word boundary, and done SHALL still pulse once per word.
REQ-030 With SEQ_GEN_REPEAT_EN undefined, the repeat_en port and reload logic SHALL be absent, and behaviour SHALL be exactly REQ-012..REQ-023.

Structure
REQ-031 Package seq_gen_pkg SHALL hold the state enum typedef (IDLE, SHIFT) and the constants MAX_WIDTH=32 and IDLE_LEVEL=1'b0.
REQ-032 Sub-module seq_bit_counter SHALL implement the parameterized load/decrement counter with a terminal-count output that drives done.
REQ-033 The top level SHALL hold the FSM, shift register, shadow register and output muxing.

Verification
REQ-034 With WIDTH=5, data=5'b10110 and a 1-cycle start pulse, j SHALL equal 1,0,1,1,0 over 5 cycles with valid=1, and done SHALL be high on cycle 5; a detector connected to j SHALL assert w on that cycle.
REQ-035 With WIDTH=8, LSB_FIRST=1 and data=8'hA5, j SHALL equal 1,0,1,0,0,1,0,1, then ready=1.
REQ-036 start asserted on cycle 3 of a word, with data changed, SHALL be ignored, and the original word SHALL complete unchanged.
REQ-037 rst asserted mid-clock-period during bit 3 SHALL take outputs to j=0, valid=0 and ready=1 before the next edge, with no done pulse.
REQ-038 With SEQ_GEN_REPEAT_EN defined, data=5'b10110 and repeat_en=1 for 3 words, j SHALL be 101101011010110 contiguous with 3 done pulses, then return to IDLE.
REQ-039 With WIDTH=1 and start held high, the sequence SHALL be valid=1, done=1, idle cycle, and repeat.
